tage_update_buf: RTL and testbench
==================================

# tage_update_buf

In-order buffer between fetch/execute and the TAGE predictor's update port. Fetch allocates one entry per predicted branch (PC plus 2-bit prediction), execute resolves entries out of order by tag, and the buffer drains resolved entries strictly in allocation order as one registered update per cycle. Its outputs drive the predictor's update_valid, update_pc, update_taken and update_pred inputs. Only resolved, non-squashed branches reach the GHR and tables, and they arrive in program order.

## Interface
- DEPTH, 8: number of entries; power of two, at least 2.
- TAG_W, $clog2(DEPTH): entry tag width.

Ports:
- clk in 1: clock.
- rst in 1: reset, synchronous, active-high.
- alloc_valid in 1: fetch requests an entry.
- alloc_ready out 1: an entry is free; asserted when count != DEPTH.
- alloc_pc in 32: branch PC.
- alloc_pred in 2: predictor counter value at fetch.
- alloc_tag out TAG_W: tag of the entry allocated this cycle; equals the tail index.
- resolve_valid in 1: execute reports an outcome.
- resolve_tag in TAG_W: entry being resolved.
- resolve_taken in 1: actual direction.
- flush_valid in 1: mispredict squash.
- flush_tag in TAG_W: mispredicted entry. It is kept; all younger entries are freed.
- update_valid out 1: registered, one-cycle pulse per drained entry.
- update_pc out 32: PC of the drained entry.
- update_taken out 1: outcome of the drained entry.
- update_pred out 2: stored prediction of the drained entry.
- count out TAG_W+1: number of occupied entries.

## Operation
**Storage and pointers**
- Circular array with head and tail indices plus an occupancy counter. Each entry holds pc, pred, taken and a 2-bit state: FREE, WAIT or DONE.

**Allocate**
- Fires when alloc_valid && alloc_ready && !flush_valid.
- Writes pc and pred at the tail, sets state to WAIT, advances tail modulo DEPTH.
- alloc_valid while full is dropped; nothing changes.

**Resolve**
- Fires when resolve_valid is high and entry[resolve_tag] is in WAIT.
- Writes taken and sets state to DONE.
- A resolve to a FREE or DONE entry is ignored, including duplicates.

**Drain**
- Fires when the head entry is DONE.
- Registers pc, taken and pred onto the update_* outputs with update_valid=1, frees the entry and advances head.
- At most one drain per cycle. update_valid=0 in every cycle without a drain; update_pc, update_taken and update_pred hold their last values.

**Flush**
- Fires when flush_valid is high and entry[flush_tag] is not FREE; otherwise it is ignored.
- New count = ((flush_tag - head) mod DEPTH) + 1, and tail = head + new count.
- Entries from flush_tag+1 up to the old tail become FREE.
- The flushed entry itself stays and still needs its own resolve.

**Simultaneous events (all evaluated against pre-edge state)**
- Flush and alloc in the same cycle: the alloc is dropped.
- Flush and resolve in the same cycle: the resolve applies only if its tag survives the flush.
- Flush and drain in the same cycle: the drain proceeds, because the head is never squashed. If flush_tag equals head, the buffer becomes empty.
- Alloc and drain while full: the alloc is refused, since alloc_ready looks only at registered count.
- Alloc and drain otherwise: both occur and count is unchanged.

**Reset**
- head = tail = 0, count = 0, all entries FREE.
- update_valid = 0, update_pc = 0, update_taken = 0, update_pred = 0.
- alloc_ready = 1, alloc_tag = 0.
- Reset in mid-operation discards all entries, with no updates emitted.

## Timing
- alloc_ready and alloc_tag are combinational from registers only; they never depend on same-cycle inputs.
- Resolve of the head in cycle N: DONE at edge N, drain during N+1, update_valid high in cycle N+2.
- Resolve of a non-head entry: it drains in the cycle after its predecessor drains, so consecutive DONE entries drain back-to-back.
- A freed slot is visible to alloc_ready in the cycle after the drain or flush.
- Throughput: 1 alloc, 1 resolve and 1 drain per cycle.

## Configuration
- With TAGE_UPD_BYPASS_EN defined: a resolve hitting the head entry while it is in WAIT drains in the same cycle using resolve_taken. update_valid is high in cycle N+1 and the entry never visits DONE.
- Without the macro: head latency is as in Timing (update_valid in cycle N+2).
- Both builds are identical in all other respects, including flush priority.

## Test plan
- **Reset:** reset, then idle → update_valid=0, count=0, alloc_ready=1, alloc_tag=0.
- **Out-of-order resolve:** alloc PCs 0x100, 0x104, 0x108 with pred 2, 1, 3. Resolve tags 2, 0, 1 with taken 1, 0, 1. → updates appear in PC order 0x100/0, 0x104/1, 0x108/1 with preds 2, 1, 3 on consecutive cycles.
- **Full:** DEPTH=8, 8 allocs with no resolve → count=8, alloc_ready=0, and a 9th alloc is dropped. Resolve tag 0 → one update; alloc_ready returns to 1 one cycle after the drain.
- **Flush:** alloc 5 entries (tags 0-4), flush_tag=1 → count=2, next alloc_tag=2. A resolve to tag 3 is ignored and only tags 0-1 ever drain.
- **Wrap-around:** run 20 alloc/resolve pairs through DEPTH=8 → 20 in-order updates, tags wrap 7→0, count returns to 0.
- **Head latency:** with TAGE_UPD_BYPASS_EN, resolve the head in cycle N → update_valid in cycle N+1. Without the macro → cycle N+2.

Source files
------------

// File: rtl/tage_update_buf.sv
// In-order update buffer between fetch/execute and the TAGE update port.
// Optional same-cycle head bypass on resolve: define TAGE_UPD_BYPASS_EN.
module tage_update_buf #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned TAG_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alloc_valid,
  output logic             alloc_ready,
  input  logic [31:0]      alloc_pc,
  input  logic [1:0]       alloc_pred,
  output logic [TAG_W-1:0] alloc_tag,
  input  logic             resolve_valid,
  input  logic [TAG_W-1:0] resolve_tag,
  input  logic             resolve_taken,
  input  logic             flush_valid,
  input  logic [TAG_W-1:0] flush_tag,
  output logic             update_valid,
  output logic [31:0]      update_pc,
  output logic             update_taken,
  output logic [1:0]       update_pred,
  output logic [TAG_W:0]   count
);

  localparam int unsigned CNT_W = TAG_W + 1;

  typedef enum logic [1:0] {
    ST_FREE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } ent_st_e;

  ent_st_e          st_q   [DEPTH];
  ent_st_e          st_n   [DEPTH];
  logic [31:0]      pc_q   [DEPTH];
  logic [1:0]       pred_q [DEPTH];
  logic             taken_q[DEPTH];

  logic [TAG_W-1:0] head_q, head_n;
  logic [TAG_W-1:0] tail_q, tail_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;

  logic             alloc_fire;
  logic             res_fire;
  logic             flush_fire;
  logic             drain;
  logic             byp;
  logic             drain_taken;
  logic [TAG_W-1:0] flush_off;
  logic [TAG_W-1:0] res_off;

  assign alloc_ready = (cnt_q != CNT_W'(DEPTH));
  assign alloc_tag   = tail_q;
  assign count       = cnt_q;

  // Event decode and next state, all from pre-edge state.
  always_comb begin
    flush_off   = TAG_W'(flush_tag - head_q);
    res_off     = TAG_W'(resolve_tag - head_q);
    flush_fire  = flush_valid && (st_q[flush_tag] != ST_FREE);
    alloc_fire  = alloc_valid && alloc_ready && !flush_valid;
    res_fire    = resolve_valid && (st_q[resolve_tag] == ST_WAIT) &&
                  (!flush_fire || (res_off <= flush_off));
`ifdef TAGE_UPD_BYPASS_EN
    byp         = res_fire && (resolve_tag == head_q);
`else
    byp         = 1'b0;
`endif
    drain       = (st_q[head_q] == ST_DONE) || byp;
    drain_taken = byp ? resolve_taken : taken_q[head_q];

    st_n = st_q;
    if (res_fire) st_n[resolve_tag] = ST_DONE;
    if (drain)    st_n[head_q]      = ST_FREE;
    // Squash everything younger than the flushed entry; the head always survives.
    if (flush_fire) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (TAG_W'(TAG_W'(i) - head_q) > flush_off) st_n[TAG_W'(i)] = ST_FREE;
      end
    end
    if (alloc_fire) st_n[tail_q] = ST_WAIT;

    head_n = head_q + TAG_W'(drain);
    if (flush_fire) begin
      tail_n = flush_tag + TAG_W'(1);
      cnt_n  = CNT_W'(flush_off) + CNT_W'(1) - CNT_W'(drain);
    end else begin
      tail_n = tail_q + TAG_W'(alloc_fire);
      cnt_n  = cnt_q + CNT_W'(alloc_fire) - CNT_W'(drain);
    end
  end

  // Pointers, entry states and the registered update port.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q       <= '0;
      tail_q       <= '0;
      cnt_q        <= '0;
      update_valid <= 1'b0;
      update_pc    <= '0;
      update_taken <= 1'b0;
      update_pred  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) st_q[i] <= ST_FREE;
    end else begin
      head_q       <= head_n;
      tail_q       <= tail_n;
      cnt_q        <= cnt_n;
      st_q         <= st_n;
      update_valid <= drain;
      if (drain) begin
        update_pc    <= pc_q[head_q];
        update_pred  <= pred_q[head_q];
        update_taken <= drain_taken;
      end
    end
  end

  // Payload storage; validity is tracked by st_q, so no reset needed.
  always_ff @(posedge clk) begin
    if (alloc_fire) begin
      pc_q[tail_q]   <= alloc_pc;
      pred_q[tail_q] <= alloc_pred;
    end
    if (res_fire) taken_q[resolve_tag] <= resolve_taken;
  end

endmodule

// File: tb/tb_tage_update_buf.sv
// Self-checking bench for tage_update_buf: per-cycle vector table plus
// hand-written full, wrap-around and head-latency sequences.
module tb_tage_update_buf;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned TAG_W = 3;
`ifdef TAGE_UPD_BYPASS_EN
  localparam int BYP = 1;
`else
  localparam int BYP = 0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             alloc_valid;
  logic             alloc_ready;
  logic [31:0]      alloc_pc;
  logic [1:0]       alloc_pred;
  logic [TAG_W-1:0] alloc_tag;
  logic             resolve_valid;
  logic [TAG_W-1:0] resolve_tag;
  logic             resolve_taken;
  logic             flush_valid;
  logic [TAG_W-1:0] flush_tag;
  logic             update_valid;
  logic [31:0]      update_pc;
  logic             update_taken;
  logic [1:0]       update_pred;
  logic [TAG_W:0]   count;

  always #5 clk = ~clk;

  tage_update_buf #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_pc(alloc_pc),
    .alloc_pred(alloc_pred), .alloc_tag(alloc_tag),
    .resolve_valid(resolve_valid), .resolve_tag(resolve_tag), .resolve_taken(resolve_taken),
    .flush_valid(flush_valid), .flush_tag(flush_tag),
    .update_valid(update_valid), .update_pc(update_pc), .update_taken(update_taken),
    .update_pred(update_pred), .count(count)
  );

  typedef struct {
    logic [31:0]      pc;
    logic [1:0]       pred;
    logic             taken;
    logic             done;
    logic [TAG_W-1:0] tag;
  } exp_t;

  typedef struct {
    int r, av, pc, pd, rv, rt, rtk, fv, ft, cnt, tag;
  } vec_t;

  exp_t             exp_q[$];
  exp_t             mon_e;
  vec_t             vecs[32];
  logic [TAG_W-1:0] m_tail;
  int               vectors = 0;
  int               miscompares = 0;
  int               n_upd = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input int r, av, pc, pd, rv, rt, rtk, fv, ft, cnt, tag);
    vec_t v;
    v.r = r; v.av = av; v.pc = pc; v.pd = pd; v.rv = rv; v.rt = rt; v.rtk = rtk;
    v.fv = fv; v.ft = ft; v.cnt = cnt; v.tag = tag;
    return v;
  endfunction

  // Drive one cycle of stimulus and update the reference queue of pending updates.
  task automatic cyc(input int r, av, pc, pd, rv, rt, rtk, fv, ft, acc);
    int   idx;
    exp_t e;
    rst           = r[0];
    alloc_valid   = av[0];
    alloc_pc      = 32'(pc);
    alloc_pred    = 2'(pd);
    resolve_valid = rv[0];
    resolve_tag   = TAG_W'(rt);
    resolve_taken = rtk[0];
    flush_valid   = fv[0];
    flush_tag     = TAG_W'(ft);
    if (r[0]) begin
      exp_q.delete();
      m_tail = '0;
    end else begin
      if (fv[0]) begin
        idx = -1;
        for (int i = exp_q.size() - 1; i >= 0; i--) begin
          if (idx < 0 && exp_q[i].tag == TAG_W'(ft)) idx = i;
        end
        if (idx >= 0) begin
          while (exp_q.size() > idx + 1) void'(exp_q.pop_back());
          m_tail = TAG_W'(ft) + TAG_W'(1);
        end
      end
      if (rv[0]) begin
        idx = -1;
        for (int i = 0; i < exp_q.size(); i++) begin
          if (idx < 0 && exp_q[i].tag == TAG_W'(rt) && !exp_q[i].done) idx = i;
        end
        if (idx >= 0) begin
          e = exp_q[idx];
          e.taken = rtk[0];
          e.done = 1'b1;
          exp_q[idx] = e;
        end
      end
      if (acc[0]) begin
        e.pc = 32'(pc); e.pred = 2'(pd); e.taken = 1'b0; e.done = 1'b0; e.tag = m_tail;
        exp_q.push_back(e);
        m_tail = m_tail + TAG_W'(1);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 30 && exp_q.size() != 0; k++) idle();
    chk("drain_done", 32'(exp_q.size()), 0);
  endtask

  // Every update pulse must match the oldest pending resolved entry.
  always @(negedge clk) begin
    if (update_valid) begin
      n_upd++;
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_update: got pc 0x%0h, want no update", update_pc);
      end else begin
        mon_e = exp_q.pop_front();
        chk("upd_resolved", 32'(mon_e.done), 1);
        chk("upd_pc", update_pc, mon_e.pc);
        chk("upd_taken", 32'(update_taken), 32'(mon_e.taken));
        chk("upd_pred", 32'(update_pred), 32'(mon_e.pred));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n0;
    //           r av pc     pd rv rt rtk fv ft cnt      tag
    vecs[0]  = mk(0, 1, 'h100, 2, 0, 0, 0, 0, 0, 1,       1);
    vecs[1]  = mk(0, 1, 'h104, 1, 0, 0, 0, 0, 0, 2,       2);
    vecs[2]  = mk(0, 1, 'h108, 3, 0, 0, 0, 0, 0, 3,       3);
    vecs[3]  = mk(0, 0, 0,     0, 1, 2, 1, 0, 0, 3,       3);
    vecs[4]  = mk(0, 0, 0,     0, 1, 0, 0, 0, 0, 3 - BYP, 3);
    vecs[5]  = mk(0, 0, 0,     0, 1, 1, 1, 0, 0, 2 - BYP, 3);
    vecs[6]  = mk(0, 0, 0,     0, 0, 0, 0, 0, 0, 1 - BYP, 3);
    vecs[7]  = mk(0, 0, 0,     0, 0, 0, 0, 0, 0, 0,       3);
    vecs[8]  = mk(0, 0, 0,     0, 0, 0, 0, 0, 0, 0,       3);
    vecs[9]  = mk(1, 0, 0,     0, 0, 0, 0, 0, 0, 0,       0);
    vecs[10] = mk(0, 1, 'h200, 0, 0, 0, 0, 0, 0, 1,       1);
    vecs[11] = mk(0, 1, 'h204, 1, 0, 0, 0, 0, 0, 2,       2);
    vecs[12] = mk(0, 1, 'h208, 2, 0, 0, 0, 0, 0, 3,       3);
    vecs[13] = mk(0, 1, 'h20C, 3, 0, 0, 0, 0, 0, 4,       4);
    vecs[14] = mk(0, 1, 'h210, 0, 0, 0, 0, 0, 0, 5,       5);
    vecs[15] = mk(0, 1, 'h300, 1, 0, 0, 0, 1, 1, 2,       2);
    vecs[16] = mk(0, 0, 0,     0, 1, 3, 1, 0, 0, 2,       2);
    vecs[17] = mk(0, 0, 0,     0, 1, 1, 0, 0, 0, 2,       2);
    vecs[18] = mk(0, 0, 0,     0, 1, 0, 1, 0, 0, 2 - BYP, 2);
    vecs[19] = mk(0, 0, 0,     0, 0, 0, 0, 0, 0, 1 - BYP, 2);
    vecs[20] = mk(0, 0, 0,     0, 0, 0, 0, 0, 0, 0,       2);
    vecs[21] = mk(0, 1, 'h220, 2, 0, 0, 0, 0, 0, 1,       3);
    vecs[22] = mk(0, 0, 0,     0, 1, 2, 1, 0, 0, 1 - BYP, 3);
    vecs[23] = mk(0, 0, 0,     0, 0, 0, 0, 0, 0, 0,       3);
    vecs[24] = mk(0, 1, 'h230, 1, 0, 0, 0, 0, 0, 1,       4);
    vecs[25] = mk(0, 1, 'h234, 2, 0, 0, 0, 0, 0, 2,       5);
    vecs[26] = mk(0, 1, 'h238, 3, 0, 0, 0, 0, 0, 3,       6);
    vecs[27] = mk(0, 0, 0,     0, 1, 5, 1, 1, 4, 2,       5);
    vecs[28] = mk(0, 0, 0,     0, 1, 4, 1, 1, 3, 1,       4);
    vecs[29] = mk(0, 0, 0,     0, 1, 3, 0, 0, 0, 1 - BYP, 4);
    vecs[30] = mk(0, 0, 0,     0, 0, 0, 0, 1, 3, 0,       4);
    vecs[31] = mk(0, 0, 0,     0, 0, 0, 0, 0, 0, 0,       4);

    m_tail = '0;
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle();
    chk("rst_count", 32'(count), 0);
    chk("rst_ready", 32'(alloc_ready), 1);
    chk("rst_tag", 32'(alloc_tag), 0);
    chk("rst_uvalid", 32'(update_valid), 0);
    chk("rst_upc", update_pc, 0);
    chk("rst_utaken", 32'(update_taken), 0);
    chk("rst_upred", 32'(update_pred), 0);

    // Out-of-order resolve, reset, flush with same-cycle alloc/resolve.
    for (int i = 0; i < 32; i++) begin
      cyc(vecs[i].r, vecs[i].av, vecs[i].pc, vecs[i].pd, vecs[i].rv, vecs[i].rt,
          vecs[i].rtk, vecs[i].fv, vecs[i].ft,
          int'(vecs[i].av != 0 && vecs[i].fv == 0 && vecs[i].r == 0));
      chk($sformatf("v%0d_count", i), 32'(count), 32'(vecs[i].cnt));
      chk($sformatf("v%0d_ready", i), 32'(alloc_ready), 32'(vecs[i].cnt != int'(DEPTH)));
      chk($sformatf("v%0d_tag", i), 32'(alloc_tag), 32'(vecs[i].tag));
    end
    wait_drain();

    // Full buffer: drop the extra alloc, then free one slot by draining the head.
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) cyc(0, 1, 'h400 + 4 * i, i % 4, 0, 0, 0, 0, 0, 1);
    chk("full_count", 32'(count), 8);
    chk("full_ready", 32'(alloc_ready), 0);
    cyc(0, 1, 'h500, 1, 0, 0, 0, 0, 0, 0);
    chk("full_drop_count", 32'(count), 8);
    chk("full_drop_tag", 32'(alloc_tag), 0);
    cyc(0, 0, 0, 0, 1, 0, 1, 0, 0, 0);
    chk("full_res_count", 32'(count), 32'(8 - BYP));
    chk("full_res_ready", 32'(alloc_ready), 32'(BYP));
    idle();
    chk("full_drain_count", 32'(count), 7);
    chk("full_drain_ready", 32'(alloc_ready), 1);
    idle();
    // Reset with live entries and a head resolve in flight: nothing may drain.
    cyc(1, 0, 0, 0, 1, 1, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) idle();
    chk("midrst_count", 32'(count), 0);
    chk("midrst_tag", 32'(alloc_tag), 0);

    // Wrap-around: 20 alloc/resolve pairs through 8 slots.
    n0 = n_upd;
    for (int i = 0; i < 20; i++)
      cyc(0, 1, 'h1000 + 4 * i, i % 4, int'(i > 0), (i + 7) % 8, (i + 1) % 2, 0, 0, 1);
    cyc(0, 0, 0, 0, 1, 3, 1, 0, 0, 0);
    wait_drain();
    chk("wrap_updates", 32'(n_upd - n0), 20);
    chk("wrap_count", 32'(count), 0);
    chk("wrap_tag", 32'(alloc_tag), 4);

    // Head resolve latency.
    cyc(0, 1, 'h2000, 3, 0, 0, 0, 0, 0, 1);
    idle();
    cyc(0, 0, 0, 0, 1, 4, 1, 0, 0, 0);
    chk("lat_n1_uvalid", 32'(update_valid), 32'(BYP));
    idle();
    chk("lat_n2_uvalid", 32'(update_valid), 32'(1 - BYP));
    wait_drain();
    chk("end_count", 32'(count), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
